// File: rtl/led_pkg.sv
// Shared definitions for the LED bank blocks: bank width, idle pattern
// reset value, scheduler state encoding and the idle-pattern rotation helper.
package led_pkg;

    localparam int LED_W = 4;

    localparam logic [LED_W-1:0] IDLE_PAT_RST = 4'b0001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Rotate the idle pattern one position to the left (MSB wraps to LSB).
    function automatic logic [LED_W-1:0] rotl1(input logic [LED_W-1:0] v);
        return {v[LED_W-2:0], v[LED_W-1]};
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler: counts 0..TICK_DIV-1 and raises a one-cycle tick
// while the count sits at its terminal value. Shared by the LED blocks.
module led_tick_gen #(
    parameter int TICK_DIV = 25000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next prescaler value, wrapping to zero after the terminal count.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end
    end

    // Count register and registered tick (high while the count equals its terminal value).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/led_sched.sv
// Round-robin owner of the LED bank. Grants the bank to one requester at a
// time for a bounded dwell (in prescaler ticks) and shows a rotating
// walking-one pattern whenever nobody holds it.
module led_sched
    import led_pkg::*;
#(
    parameter int TICK_DIV    = 25000000,
    parameter int N_REQ       = 4,
    parameter int DWELL_TICKS = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [LED_W*N_REQ-1:0] pat,
    output logic [N_REQ-1:0]       grant,
    output logic [LED_W-1:0]       led,
    output logic                   tick,
    output logic                   busy
);

    localparam int                OW_W     = $clog2(N_REQ);
    localparam int                DW_W     = $clog2(DWELL_TICKS) + 1;
    localparam logic [DW_W-1:0]   DW_LAST  = DW_W'(DWELL_TICKS - 1);
    localparam logic [OW_W-1:0]   LAST_RST = OW_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]  ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    state_t            state_r,      state_nxt_s;
    logic [N_REQ-1:0]  grant_r,      grant_nxt_s;
    logic [LED_W-1:0]  led_r,        led_nxt_s;
    logic              busy_r,       busy_nxt_s;
    logic [LED_W-1:0]  idle_pat_r,   idle_pat_nxt_s;
    logic [DW_W-1:0]   dwell_r,      dwell_nxt_s;
    logic [OW_W-1:0]   last_owner_r, last_owner_nxt_s;

    logic              tick_s;
    logic [N_REQ-1:0]  req_search_s;
    logic [OW_W-1:0]   rr_idx_s;
    logic              rr_found_s;
    logic              owner_req_s;
    logic              expiry_s;
    logic [LED_W-1:0]  owner_pat_s;
    logic [LED_W-1:0]  rr_pat_s;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick_s)
    );

    // The owner is always the most recent grantee, so last_owner doubles as the owner index.
    assign owner_req_s = req[last_owner_r];
    assign owner_pat_s = pat[int'(last_owner_r)*LED_W +: LED_W];
    assign rr_pat_s    = pat[int'(rr_idx_s)*LED_W +: LED_W];
    assign expiry_s    = tick_s & (dwell_r == DW_LAST);

    // Round-robin search from last_owner+1 with wrap; while granted the owner is masked out
    // so "found" means another requester is pending. Scanning from the far end lets the
    // nearest candidate overwrite earlier hits.
    always_comb begin
        int cand_v;
        cand_v     = 0;
        rr_idx_s   = last_owner_r;
        rr_found_s = 1'b0;
        if (state_r == ST_GRANT) begin
            req_search_s = req & ~(ONE_HOT0 << last_owner_r);
        end else begin
            req_search_s = req;
        end
        for (int k = N_REQ; k >= 1; k--) begin
            cand_v = (int'(last_owner_r) + k) % N_REQ;
            if (req_search_s[cand_v]) begin
                rr_idx_s   = OW_W'(cand_v);
                rr_found_s = 1'b1;
            end else begin
                rr_idx_s   = rr_idx_s;
                rr_found_s = rr_found_s;
            end
        end
    end

    // Scheduler next-state and output decode.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        led_nxt_s        = led_r;
        busy_nxt_s       = busy_r;
        idle_pat_nxt_s   = idle_pat_r;
        dwell_nxt_s      = dwell_r;
        last_owner_nxt_s = last_owner_r;

        case (state_r)
            ST_IDLE: begin
                if (tick_s) begin
                    idle_pat_nxt_s = rotl1(idle_pat_r);
                end else begin
                    idle_pat_nxt_s = idle_pat_r;
                end
                if (rr_found_s) begin
                    state_nxt_s      = ST_GRANT;
                    grant_nxt_s      = ONE_HOT0 << rr_idx_s;
                    led_nxt_s        = rr_pat_s;
                    busy_nxt_s       = 1'b1;
                    dwell_nxt_s      = {DW_W{1'b0}};
                    last_owner_nxt_s = rr_idx_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = {N_REQ{1'b0}};
                    led_nxt_s   = idle_pat_nxt_s;
                    busy_nxt_s  = 1'b0;
                end
            end

            ST_GRANT: begin
                if (!owner_req_s || expiry_s) begin
                    // A drop takes precedence over a coincident expiry; both hand over if possible.
                    if (rr_found_s) begin
                        grant_nxt_s      = ONE_HOT0 << rr_idx_s;
                        led_nxt_s        = rr_pat_s;
                        dwell_nxt_s      = {DW_W{1'b0}};
                        last_owner_nxt_s = rr_idx_s;
                    end else if (!owner_req_s) begin
                        state_nxt_s = ST_IDLE;
                        grant_nxt_s = {N_REQ{1'b0}};
                        led_nxt_s   = idle_pat_r;
                        busy_nxt_s  = 1'b0;
                    end else begin
                        // Expiry with nobody waiting: keep the bank and start a fresh dwell.
                        led_nxt_s   = owner_pat_s;
                        dwell_nxt_s = {DW_W{1'b0}};
                    end
                end else begin
                    led_nxt_s = owner_pat_s;
                    if (tick_s) begin
                        dwell_nxt_s = dwell_r + DW_W'(1);
                    end else begin
                        dwell_nxt_s = dwell_r;
                    end
                end
            end

            default: begin
                state_nxt_s      = ST_IDLE;
                grant_nxt_s      = {N_REQ{1'b0}};
                led_nxt_s        = IDLE_PAT_RST;
                busy_nxt_s       = 1'b0;
                idle_pat_nxt_s   = IDLE_PAT_RST;
                dwell_nxt_s      = {DW_W{1'b0}};
                last_owner_nxt_s = LAST_RST;
            end
        endcase
    end

    // Scheduler state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= {N_REQ{1'b0}};
            led_r        <= IDLE_PAT_RST;
            busy_r       <= 1'b0;
            idle_pat_r   <= IDLE_PAT_RST;
            dwell_r      <= {DW_W{1'b0}};
            last_owner_r <= LAST_RST;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            led_r        <= led_nxt_s;
            busy_r       <= busy_nxt_s;
            idle_pat_r   <= idle_pat_nxt_s;
            dwell_r      <= dwell_nxt_s;
            last_owner_r <= last_owner_nxt_s;
        end
    end

    assign grant = grant_r;
    assign led   = led_r;
    assign busy  = busy_r;
    assign tick  = tick_s;

endmodule

// File: tb/tb_led_sched.sv
// Randomized bench for led_sched with a behavioural reference model
// (TICK_DIV=4, DWELL_TICKS=2, N_REQ=4), plus the directed scenarios.
module tb_led_sched;

    localparam int TD = 4;
    localparam int NR = 4;
    localparam int DT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  grant;
    logic [3:0]  led;
    logic        tick;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit         m_busy;
    int         m_owner;   // current owner when busy, otherwise last owner
    int         m_dwell;
    logic [3:0] m_idle;
    logic [3:0] m_led;
    int         ccount;    // clock edges since reset release

    led_sched #(
        .TICK_DIV    (TD),
        .N_REQ       (NR),
        .DWELL_TICKS (DT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .pat   (pat),
        .grant (grant),
        .led   (led),
        .tick  (tick),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int from, input int skip);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (from + k) % NR;
            if (c != skip && r[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = NR - 1;
        m_dwell = 0;
        m_idle  = 4'b0001;
        m_led   = 4'b0001;
        ccount  = 0;
    endtask

    task automatic model_grant(input int n, input logic [15:0] p);
        m_busy  = 1'b1;
        m_owner = n;
        m_dwell = 0;
        m_led   = p[n*4 +: 4];
    endtask

    task automatic model_update(input logic [3:0] r, input logic [15:0] p, input bit tk);
        int n;
        if (!m_busy) begin
            if (tk) m_idle = (m_idle == 4'b1000) ? 4'b0001 : (m_idle * 4'd2);
            n = rr_pick(r, m_owner, -1);
            if (n >= 0) model_grant(n, p);
            else m_led = m_idle;
        end else begin
            n = rr_pick(r, m_owner, m_owner);
            if (!r[m_owner]) begin
                if (n >= 0) model_grant(n, p);
                else begin
                    m_busy = 1'b0;
                    m_led  = m_idle;
                end
            end else if (tk && m_dwell == DT - 1) begin
                if (n >= 0) model_grant(n, p);
                else begin
                    m_dwell = 0;
                    m_led   = p[m_owner*4 +: 4];
                end
            end else begin
                if (tk) m_dwell++;
                m_led = p[m_owner*4 +: 4];
            end
        end
    endtask

    task automatic compare_all();
        logic [31:0] eg;
        eg = m_busy ? (32'd1 << m_owner) : 32'd0;
        chk("grant", {28'd0, grant}, eg);
        chk("led",   {28'd0, led},   {28'd0, m_led});
        chk("busy",  {31'd0, busy},  {31'd0, m_busy});
        chk("tick",  {31'd0, tick},  {31'd0, (ccount % TD) == TD - 1});
    endtask

    // Apply inputs, take one clock edge, advance the model, check just after the edge.
    task automatic step(input logic [3:0] r, input logic [15:0] p);
        bit tk;
        req = r;
        pat = p;
        @(posedge clk);
        tk = ((ccount % TD) == TD - 1);
        model_update(r, p, tk);
        ccount++;
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between edges; outputs must clear without a clock edge.
    task automatic pulse_reset();
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_led",   {28'd0, led},   32'd1);
        chk("rst_busy",  {31'd0, busy},  32'd0);
        chk("rst_tick",  {31'd0, tick},  32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] p2;
        logic [3:0]  rr;
        int k;

        rst = 1'b1;
        req = 4'b0000;
        pat = 16'h0000;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst = 1'b0;

        // idle rotation with no requests
        for (int i = 1; i <= 20; i++) begin
            step(4'b0000, 16'($urandom));
            if (i == 4) chk("s1_rot4", {28'd0, led}, 32'h2);
            if (i == 8) chk("s1_rot8", {28'd0, led}, 32'h4);
        end

        // req 0101: grant 0, expiry to 2, expiry back to 0
        p2 = 16'h050A;
        step(4'b0101, p2);
        chk("s2_grant0", {28'd0, grant}, 32'h1);
        chk("s2_led0",   {28'd0, led},   32'hA);
        for (k = 0; k < 30 && grant !== 4'b0100; k++) step(4'b0101, p2);
        chk("s2_grant2", {28'd0, grant}, 32'h4);
        chk("s2_led2",   {28'd0, led},   32'h5);
        for (k = 0; k < 30 && grant !== 4'b0001; k++) step(4'b0101, p2);
        chk("s2_back0", {28'd0, grant}, 32'h1);

        // sole requester keeps the bank across expiries
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, {12'h000, 4'($urandom)});
            chk("s3_hold", {28'd0, grant}, 32'h1);
        end

        // owner drop coinciding with expiry, req2 pending
        for (k = 0; k < 40 && !(m_busy && m_owner == 0 && m_dwell == DT - 1 && (ccount % TD) == TD - 1); k++)
            step(4'b0101, p2);
        chk("s4_aligned", k < 40, 1);
        step(4'b0100, p2);
        chk("s4_grant2", {28'd0, grant}, 32'h4);
        for (int i = 0; i < 12; i++) step(4'b0101, p2);

        // reset mid-grant, then req0 wins first
        pulse_reset();
        step(4'b1111, 16'h4321);
        chk("s5_first", {28'd0, grant}, 32'h1);
        for (int i = 0; i < 6; i++) step(4'b1111, 16'($urandom));

        // drop with idle pattern held at 0100
        pulse_reset();
        for (int i = 0; i < 8; i++) step(4'b0000, 16'h0007);
        step(4'b0001, 16'h0007);
        for (int i = 0; i < 5; i++) step(4'b0001, 16'h0007);
        step(4'b0000, 16'h0007);
        chk("s6_held", {28'd0, led}, 32'h4);
        chk("s6_idle", {28'd0, grant}, 32'h0);
        for (k = 0; k < 8 && led === 4'b0100; k++) step(4'b0000, 16'h0007);
        chk("s6_rot", {28'd0, led}, 32'h8);

        // randomized traffic
        rr = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) pulse_reset();
            if ($urandom_range(0, 4) == 0) rr = 4'($urandom);
            step(rr, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/led_sched.md
# led_sched

Round-robin scheduler that shares the 4-bit LED bank between up to N_REQ pattern requesters on the 50 MHz board clock. It owns a tick prescaler and grants the bank to one requester at a time for a bounded dwell measured in ticks. It drives a walking-one idle pattern when no requester holds the bank. It sits between the pattern-producing blocks and the top-level `led` pins.

## Interface
- `TICK_DIV`, 25000000: clk cycles per tick (0.5 s at 50 MHz); ≥2
- `N_REQ`, 4: number of requesters; 2..8
- `DWELL_TICKS`, 8: ticks a grant may be held while others wait; ≥1
- `clk`  in  1  board clock, 50 MHz; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req`  in  N_REQ  level request, bit i = requester i
- `pat`  in  4*N_REQ  requester i pattern at bits [4i+3:4i]
- `grant`  out  N_REQ  one-hot registered grant, all-zero when idle
- `led`  out  4  LED bank drive, registered
- `tick`  out  1  one-cycle pulse every TICK_DIV cycles
- `busy`  out  1  high while in GRANT

## Operation
- Prescaler counts 0..TICK_DIV-1 and wraps to 0. `tick`=1 for the cycle in which the count equals TICK_DIV-1. It runs free in every state.
- States: IDLE, GRANT.
- IDLE:
  - `grant`=0 and `busy`=0.
  - `led` shows the idle pattern, which rotates left on each tick: 0001→0010→0100→1000→0001.
  - If any `req` bit is set, the next owner is the first requester with `req` set, searching from last_owner+1 upward and wrapping. The block then enters GRANT.
- GRANT:
  - `led` tracks `pat` of the owner each cycle.
  - The dwell counter increments on each tick. Expiry is a tick while dwell == DWELL_TICKS-1.
- Exit from GRANT, evaluated every cycle:
  - The owner's `req` drops. If another req is pending, switch directly to the next round-robin owner. Otherwise go to IDLE.
  - Expiry occurs and another req is pending: switch directly to the next round-robin owner. The current owner is skipped in the search even if it is still requesting.
  - Expiry occurs and no other req is pending: stay in GRANT and reset dwell to 0.
- Every new grant, including a direct switch, clears dwell to 0 and updates last_owner.
- An owner drop and expiry in the same cycle are handled as a drop.
- The idle pattern holds its value during GRANT and resumes from that value on return to IDLE.
- `pat` of non-owners is ignored. `req` is sampled every cycle; no request latching.
- Widths:
  - prescaler is $clog2(TICK_DIV) bits
  - dwell is $clog2(DWELL_TICKS)+1 bits
  - last_owner is $clog2(N_REQ) bits
  - no arithmetic overflow is permitted

## Timing
- Reset values:
  - state IDLE, `grant`=0, `busy`=0, `tick`=0
  - `led`=4'b0001, idle pattern 4'b0001
  - prescaler 0, dwell 0
  - last_owner=N_REQ-1, so requester 0 wins first
- `req` rising in IDLE at edge k: at edge k+1, `grant`, `busy` and `led`=`pat`[owner] all update together.
- In GRANT, a `pat` change at edge k appears on `led` at edge k+1.
- Owner `req` low at edge k: at edge k+1, `grant` moves to the next owner or to 0. `led` follows on the same edge: new `pat` or the held idle pattern.
- Expiry switch: `grant` changes at the edge after the expiry tick cycle.
- First tick after reset is at cycle TICK_DIV-1, counting from release of reset.
- `rst` asserted mid-grant: all outputs take their reset values immediately, without waiting for a clock edge.

## Structure
- Shared package `led_pkg`:
  - state encoding (IDLE, GRANT)
  - LED_W=4
  - IDLE_PAT_RST=4'b0001
- Sub-module `led_tick_gen`: the prescaler with parameter TICK_DIV and ports `clk`, `rst`, `tick`. It is reused by other LED blocks.
- Round-robin search is combinational inside led_sched. It returns an index and a found flag.

## Test plan
Parameters for all scenarios: TICK_DIV=4, DWELL_TICKS=2, N_REQ=4.
- Reset, no req for 20 cycles → tick at cycles 3,7,11…; `led` goes 0001→0010→0100→1000→0001, advancing the edge after each tick; `grant`=0.
- `req`=0101 from IDLE, `pat`=A,_,5,_ → next edge `grant`=0001 and `led`=A. After 2 ticks, expiry gives `grant`=0100 and `led`=5. After 2 more ticks `grant`=0001 again.
- Only req0 high, held 20 cycles → `grant` stays 0001 across repeated expiries; `led` tracks each `pat0` change with 1-cycle latency.
- Owner req drop and expiry in the same cycle, with req2 pending → handled as drop; `grant`=0100 and dwell restarts at 0.
- `rst` pulsed mid-grant between edges → `grant`=0, `led`=0001, `busy`=0 immediately. After release, first tick comes 4 cycles later and req0 wins first.
- Owner drops with no others pending while idle pattern held 0100 → IDLE on the next edge with `led`=0100; rotates to 1000 on the next tick.
